// File: rtl/cond_flag_unit_if.sv
// ---------------------------------------------------------------------------
// cond_flag_unit_if
//   Bundles the per-instruction request (condition, ALU flags, write intents)
//   and the gated write enables / flag / counter results of cond_flag_unit.
//
//   master : decode/execute side, drives the request, observes the results
//   slave  : cond_flag_unit itself
//
//   Request : valid_i, Cond[3:0], ALUFlags[3:0] {V,C,N,Z}, FlagW[1:0],
//             PCS, RegW, MemW, cnt_clr
//   Result  : PCSrc, RegWrite, MemWrite, CondEx, squash_o, Flags[3:0],
//             exec_count[CNT_W-1:0], squash_count[CNT_W-1:0]
// ---------------------------------------------------------------------------
interface cond_flag_unit_if #(
    parameter int CNT_W = 32
);
    logic             valid_i;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             cnt_clr;

    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic             squash_o;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] squash_count;

    modport master (
        output valid_i, Cond, ALUFlags, FlagW, PCS, RegW, MemW, cnt_clr,
        input  PCSrc, RegWrite, MemWrite, CondEx, squash_o, Flags,
               exec_count, squash_count
    );

    modport slave (
        input  valid_i, Cond, ALUFlags, FlagW, PCS, RegW, MemW, cnt_clr,
        output PCSrc, RegWrite, MemWrite, CondEx, squash_o, Flags,
               exec_count, squash_count
    );
endinterface

// File: rtl/cond_flag_unit.sv
// ---------------------------------------------------------------------------
// cond_flag_unit
//   Condition-evaluation and flag-holding stage. Evaluates each instruction's
//   condition field against the architectural flag register {V,C,N,Z}, gates
//   register / memory / PC writes, updates the flags as directed and squashes
//   the SHADOW valid instructions that follow a taken branch.
//
//   Parameters
//     SHADOW : valid instructions squashed after a taken branch (0 = none)
//     CNT_W  : width of the execute / squash performance counters
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : cond_flag_unit_if.slave (request in, enables/flags/counters out)
// ---------------------------------------------------------------------------
module cond_flag_unit #(
    parameter int SHADOW = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    cond_flag_unit_if.slave   bus
);

    // A zero-length shadow would give a zero-width counter; keep one bit,
    // it is simply never loaded with anything but 0.
    localparam int              SH_W    = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;
    localparam logic [SH_W-1:0] SH_LOAD = SH_W'(SHADOW);

    logic [3:0]       flags_q;     // {V,C,N,Z}
    logic [SH_W-1:0]  shadow_q;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] squash_q;

    logic flag_v, flag_c, flag_n, flag_z;
    logic cond_pass;
    logic cond_ex;
    logic squash;
    logic go;
    logic pc_src;

    assign flag_v = flags_q[3];
    assign flag_c = flags_q[2];
    assign flag_n = flags_q[1];
    assign flag_z = flags_q[0];

    // Condition decode against registered flags only: no bypass of this
    // cycle's ALUFlags.
    // NOTE: every always_comb output gets a default before the case so that
    // no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        cond_pass = 1'b0;
        case (bus.Cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c & !flag_z;
            4'h9: cond_pass = !flag_c | flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z & (flag_n == flag_v);
            4'hD: cond_pass = flag_z | (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Every combinational result is held low while reset is asserted, so a
    // reset landing mid-cycle cannot let a write escape.
    assign cond_ex = cond_pass & !rst;
    assign squash  = bus.valid_i & (shadow_q != '0) & !rst;
    assign go      = bus.valid_i & cond_ex & !squash;
    assign pc_src  = go & bus.PCS;

    assign bus.CondEx       = cond_ex;
    assign bus.squash_o     = squash;
    assign bus.PCSrc        = pc_src;
    assign bus.RegWrite     = go & bus.RegW;
    assign bus.MemWrite     = go & bus.MemW;
    assign bus.Flags        = flags_q;
    assign bus.exec_count   = exec_q;
    assign bus.squash_count = squash_q;

    // Flag register: N,Z and C,V groups are written independently.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (go) begin
            if (bus.FlagW[1]) flags_q[1:0] <= bus.ALUFlags[1:0];
            if (bus.FlagW[0]) flags_q[3:2] <= bus.ALUFlags[3:2];
        end
    end

    // Shadow counter. Only an executed branch reloads it (a squashed one has
    // go=0), and bubbles leave it untouched because squash needs valid_i.
    // pc_src and squash are mutually exclusive by construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (pc_src) begin
            shadow_q <= SH_LOAD;
        end else if (squash) begin
            shadow_q <= shadow_q - SH_W'(1);
        end
    end

    // Performance counters wrap naturally; clear wins over a same-cycle
    // increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (bus.cnt_clr) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            if (go)     exec_q   <= exec_q + CNT_W'(1);
            if (squash) squash_q <= squash_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_flag_unit
//   Directed bench for cond_flag_unit. Main instance: SHADOW=2, CNT_W=32.
//   Second instance: SHADOW=0, CNT_W=4, for counter wrap and the
//   no-squash configuration. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_cond_flag_unit;

    logic clk;
    logic rst;

    int n_pass  = 0;
    int n_total = 0;

    cond_flag_unit_if #(.CNT_W(32)) bus  ();
    cond_flag_unit_if #(.CNT_W(4))  bus4 ();

    cond_flag_unit #(.SHADOW(2), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cond_flag_unit #(.SHADOW(0), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_i  = 1'b0;
        bus.Cond     = 4'hF;
        bus.ALUFlags = 4'b0000;
        bus.FlagW    = 2'b00;
        bus.PCS      = 1'b0;
        bus.RegW     = 1'b0;
        bus.MemW     = 1'b0;
        bus.cnt_clr  = 1'b0;
        bus4.valid_i  = 1'b0;
        bus4.Cond     = 4'hF;
        bus4.ALUFlags = 4'b0000;
        bus4.FlagW    = 2'b00;
        bus4.PCS      = 1'b0;
        bus4.RegW     = 1'b0;
        bus4.MemW     = 1'b0;
        bus4.cnt_clr  = 1'b0;
    endtask

    // Single AL-conditioned instruction on the main instance.
    task automatic issue(input logic [1:0] flag_w, input logic [3:0] alu,
                         input logic pcs, input logic reg_w);
        bus.valid_i  = 1'b1;
        bus.Cond     = 4'hE;
        bus.FlagW    = flag_w;
        bus.ALUFlags = alu;
        bus.PCS      = pcs;
        bus.RegW     = reg_w;
        bus.MemW     = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        // Live request while reset is held: everything must stay low.
        bus.valid_i = 1'b1; bus.Cond = 4'hE;
        bus.RegW = 1'b1; bus.MemW = 1'b1; bus.PCS = 1'b1;
        #2;
        n_total++;
        if (bus.Flags !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", bus.Flags);
        else n_pass++;
        n_total++;
        if (bus.exec_count !== 32'd0 || bus.squash_count !== 32'd0)
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.exec_count, bus.squash_count);
        else n_pass++;
        n_total++;
        if ({bus.RegWrite, bus.MemWrite, bus.PCSrc, bus.CondEx, bus.squash_o} !== 5'b00000)
            $display("FAIL reset_enables got=%b exp=00000",
                     {bus.RegWrite, bus.MemWrite, bus.PCSrc, bus.CondEx, bus.squash_o});
        else n_pass++;
        idle();
        tick();
        rst = 1'b0;
        #2;
    endtask

    task automatic test_first_exec();
        issue(2'b11, 4'b0101, 1'b0, 1'b1);
        #2;
        n_total++;
        if (bus.RegWrite !== 1'b1) $display("FAIL first_regwrite got=%b exp=1", bus.RegWrite);
        else n_pass++;
        n_total++;
        if (bus.Flags !== 4'b0000) $display("FAIL first_no_bypass got=%b exp=0000", bus.Flags);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.Flags !== 4'b0101) $display("FAIL first_flags got=%b exp=0101", bus.Flags);
        else n_pass++;
        n_total++;
        if (bus.exec_count !== 32'd1) $display("FAIL first_exec_count got=%0d exp=1", bus.exec_count);
        else n_pass++;
    endtask

    // Flags = 0101: V=0 C=1 N=0 Z=1. valid_i stays low so nothing changes.
    task automatic test_cond_sweep();
        logic exp_pat [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        idle();
        for (int i = 0; i < 16; i++) begin
            bus.Cond = 4'(i);
            #1;
            n_total++;
            if (bus.CondEx !== exp_pat[i])
                $display("FAIL cond_sweep cond=%h got=%b exp=%b", i[3:0], bus.CondEx, exp_pat[i]);
            else n_pass++;
        end
        idle();
        tick();
    endtask

    task automatic test_partial();
        issue(2'b11, 4'b0000, 1'b0, 1'b0);   // clear all flags
        tick();
        n_total++;
        if (bus.Flags !== 4'b0000) $display("FAIL partial_clear got=%b exp=0000", bus.Flags);
        else n_pass++;
        issue(2'b10, 4'b1111, 1'b0, 1'b0);   // N,Z only
        tick();
        n_total++;
        if (bus.Flags !== 4'b0011) $display("FAIL partial_nz got=%b exp=0011", bus.Flags);
        else n_pass++;
        issue(2'b01, 4'b0000, 1'b0, 1'b0);   // C,V <= 00
        tick();
        n_total++;
        if (bus.Flags !== 4'b0011) $display("FAIL partial_cv0 got=%b exp=0011", bus.Flags);
        else n_pass++;
        issue(2'b01, 4'b1100, 1'b0, 1'b0);   // C,V <= 11
        tick();
        idle();
        n_total++;
        if (bus.Flags !== 4'b1111) $display("FAIL partial_cv1 got=%b exp=1111", bus.Flags);
        else n_pass++;
    endtask

    task automatic test_failed_cond();
        issue(2'b11, 4'b0000, 1'b0, 1'b0);   // Z=0; exec_count 5 -> 6
        tick();
        bus.valid_i = 1'b1; bus.Cond = 4'h0;  // EQ with Z=0 fails
        bus.RegW = 1'b1; bus.MemW = 1'b1; bus.PCS = 1'b1;
        bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
        #2;
        n_total++;
        if ({bus.RegWrite, bus.MemWrite, bus.PCSrc, bus.CondEx} !== 4'b0000)
            $display("FAIL failcond_enables got=%b exp=0000",
                     {bus.RegWrite, bus.MemWrite, bus.PCSrc, bus.CondEx});
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.Flags !== 4'b0000) $display("FAIL failcond_flags got=%b exp=0000", bus.Flags);
        else n_pass++;
        n_total++;
        if (bus.exec_count !== 32'd6) $display("FAIL failcond_exec got=%0d exp=6", bus.exec_count);
        else n_pass++;
    endtask

    task automatic test_branch_shadow();
        issue(2'b00, 4'b0000, 1'b1, 1'b0);   // taken branch
        #2;
        n_total++;
        if (bus.PCSrc !== 1'b1 || bus.squash_o !== 1'b0)
            $display("FAIL shadow_branch pcsrc/squash got=%b%b exp=10", bus.PCSrc, bus.squash_o);
        else n_pass++;
        tick();
        idle();                              // bubble
        #2;
        n_total++;
        if (bus.squash_o !== 1'b0) $display("FAIL shadow_bubble got=%b exp=0", bus.squash_o);
        else n_pass++;
        tick();
        issue(2'b00, 4'b0000, 1'b1, 1'b1);   // branch in the shadow
        #2;
        n_total++;
        if ({bus.squash_o, bus.PCSrc, bus.RegWrite, bus.CondEx} !== 4'b1001)
            $display("FAIL shadow_sq1 got=%b exp=1001",
                     {bus.squash_o, bus.PCSrc, bus.RegWrite, bus.CondEx});
        else n_pass++;
        tick();
        issue(2'b00, 4'b0000, 1'b0, 1'b1);
        #2;
        n_total++;
        if ({bus.squash_o, bus.RegWrite} !== 2'b10)
            $display("FAIL shadow_sq2 got=%b exp=10", {bus.squash_o, bus.RegWrite});
        else n_pass++;
        tick();
        issue(2'b00, 4'b0000, 1'b0, 1'b1);   // must execute: no reload
        #2;
        n_total++;
        if ({bus.squash_o, bus.RegWrite} !== 2'b01)
            $display("FAIL shadow_third got=%b exp=01", {bus.squash_o, bus.RegWrite});
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.squash_count !== 32'd2) $display("FAIL shadow_squash_count got=%0d exp=2", bus.squash_count);
        else n_pass++;
        n_total++;
        if (bus.exec_count !== 32'd8) $display("FAIL shadow_exec_count got=%0d exp=8", bus.exec_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_shadow();
        issue(2'b11, 4'b1010, 1'b1, 1'b0);   // taken branch that also sets flags
        tick();
        issue(2'b00, 4'b0000, 1'b0, 1'b1);
        #2;
        n_total++;
        if (bus.Flags !== 4'b1010 || bus.squash_o !== 1'b1)
            $display("FAIL midshadow_pre flags/squash got=%b/%b exp=1010/1", bus.Flags, bus.squash_o);
        else n_pass++;
        rst = 1'b1;                          // asynchronous, mid-cycle
        #2;
        n_total++;
        if (bus.Flags !== 4'b0000 || bus.exec_count !== 32'd0 || bus.squash_count !== 32'd0)
            $display("FAIL midshadow_reset got=%b/%0d/%0d exp=0000/0/0",
                     bus.Flags, bus.exec_count, bus.squash_count);
        else n_pass++;
        n_total++;
        if ({bus.squash_o, bus.RegWrite} !== 2'b00)
            $display("FAIL midshadow_forced got=%b exp=00", {bus.squash_o, bus.RegWrite});
        else n_pass++;
        tick();
        rst = 1'b0;
        #2;
        n_total++;
        if ({bus.squash_o, bus.RegWrite} !== 2'b01)
            $display("FAIL midshadow_after got=%b exp=01", {bus.squash_o, bus.RegWrite});
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.exec_count !== 32'd1) $display("FAIL midshadow_exec got=%0d exp=1", bus.exec_count);
        else n_pass++;
    endtask

    task automatic test_cnt_clr();
        issue(2'b00, 4'b0000, 1'b0, 1'b1);
        bus.cnt_clr = 1'b1;
        tick();
        idle();
        n_total++;
        if (bus.exec_count !== 32'd0) $display("FAIL cnt_clr_exec got=%0d exp=0", bus.exec_count);
        else n_pass++;
    endtask

    // SHADOW=0, CNT_W=4: back-to-back taken branches never squash, and the
    // 16th execution wraps the counter to 0.
    task automatic test_wrap();
        int squashed;
        squashed = 0;
        n_total++;
        if (bus4.exec_count !== 4'd0) $display("FAIL wrap_start got=%0d exp=0", bus4.exec_count);
        else n_pass++;
        bus4.valid_i = 1'b1; bus4.Cond = 4'hE; bus4.PCS = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #2;
            if (bus4.squash_o !== 1'b0 || bus4.PCSrc !== 1'b1) squashed++;
            tick();
            if (i == 14) begin
                n_total++;
                if (bus4.exec_count !== 4'd15) $display("FAIL wrap_15 got=%0d exp=15", bus4.exec_count);
                else n_pass++;
            end
        end
        idle();
        n_total++;
        if (bus4.exec_count !== 4'd0) $display("FAIL wrap_16 got=%0d exp=0", bus4.exec_count);
        else n_pass++;
        n_total++;
        if (squashed != 0 || bus4.squash_count !== 4'd0)
            $display("FAIL wrap_no_squash got=%0d/%0d exp=0/0", squashed, bus4.squash_count);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        test_reset();
        test_first_exec();
        test_cond_sweep();
        test_partial();
        test_failed_cond();
        test_branch_shadow();
        test_reset_mid_shadow();
        test_cnt_clr();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
